// File: rtl/store_data_queue.sv
// store_data_queue: aligns MEM stores into word address/data/strobe and
// buffers them in an in-order FIFO whose head drives a valid/ack write port.
// Ports: st_* store request in (valid/ready/err), mem_* write port out with
// mem_ack_i, ld_addr_i/ld_hit_o load-hazard probe, empty_o drain status.
// Build option: STORE_UNALIGNED_EN enables SWL/SWR (otherwise they error).

package store_pkg;
   localparam logic [3:0] STORE_NONE = 4'd0;
   localparam logic [3:0] STORE_SB   = 4'd1;
   localparam logic [3:0] STORE_SH   = 4'd2;
   localparam logic [3:0] STORE_SW   = 4'd3;
   localparam logic [3:0] STORE_SC   = 4'd4;
   localparam logic [3:0] STORE_SWL  = 4'd5;
   localparam logic [3:0] STORE_SWR  = 4'd6;
endpackage

module store_data_queue
   import store_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        st_valid_i,
   output logic        st_ready_o,
   input  logic [3:0]  store_type_i,
   input  logic [31:0] st_addr_i,
   input  logic [31:0] st_data_i,
   output logic        st_err_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wstrb_o,
   input  logic        mem_ack_i,
   input  logic [31:0] ld_addr_i,
   output logic        ld_hit_o,
   output logic        empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, REQ} state_t;

   state_t        state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_nxt;
   logic [CW-1:0] count;
   logic          full;
   logic          push;
   logic          pop;

   logic [29:0]   q_addr [DEPTH];
   logic [31:0]   q_data [DEPTH];
   logic [3:0]    q_strb [DEPTH];

   logic          is_st;
   logic          bad;
   logic [3:0]    a_strb;
   logic [31:0]   a_data;
   logic [1:0]    o;

   assign o = st_addr_i[1:0];

   always_comb begin
      is_st  = 1'b1;
      bad    = 1'b0;
      a_strb = 4'b0000;
      a_data = 32'h0;
      case (store_type_i)
         STORE_SB: begin
            a_strb = 4'b0001 << o;
            a_data = {4{st_data_i[7:0]}};
         end
         STORE_SH: begin
            bad    = o[0];
            a_strb = o[1] ? 4'b1100 : 4'b0011;
            a_data = {2{st_data_i[15:0]}};
         end
         STORE_SW, STORE_SC: begin
            bad    = (o != 2'b00);
            a_strb = 4'b1111;
            a_data = st_data_i;
         end
`ifdef STORE_UNALIGNED_EN
         STORE_SWL: begin
            case (o)
               2'd0: begin
                  a_strb = 4'b0001;
                  a_data = {24'h0, st_data_i[31:24]};
               end
               2'd1: begin
                  a_strb = 4'b0011;
                  a_data = {16'h0, st_data_i[31:16]};
               end
               2'd2: begin
                  a_strb = 4'b0111;
                  a_data = {8'h0, st_data_i[31:8]};
               end
               default: begin
                  a_strb = 4'b1111;
                  a_data = st_data_i;
               end
            endcase
         end
         STORE_SWR: begin
            case (o)
               2'd0: begin
                  a_strb = 4'b1111;
                  a_data = st_data_i;
               end
               2'd1: begin
                  a_strb = 4'b1110;
                  a_data = {st_data_i[23:0], 8'h0};
               end
               2'd2: begin
                  a_strb = 4'b1100;
                  a_data = {st_data_i[15:0], 16'h0};
               end
               default: begin
                  a_strb = 4'b1000;
                  a_data = {st_data_i[7:0], 24'h0};
               end
            endcase
         end
`else
         STORE_SWL, STORE_SWR: begin
            bad = 1'b1;
         end
`endif
         default: begin
            is_st = 1'b0;
         end
      endcase
   end

   assign full       = (count == CW'(DEPTH));
   assign st_ready_o = !full;
   assign st_err_o   = st_valid_i & is_st & bad;
   assign push       = st_valid_i & is_st & !bad & !full;
   assign pop        = (state == REQ) & mem_ack_i;
   assign empty_o    = (count == '0);
   assign rd_nxt     = rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr] <= st_addr_i[31:2];
         q_data[wr_ptr] <= a_data;
         q_strb[wr_ptr] <= a_strb;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         state       <= IDLE;
         mem_req_o   <= 1'b0;
         mem_addr_o  <= 32'h0;
         mem_wdata_o <= 32'h0;
         mem_wstrb_o <= 4'h0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_nxt;
         count <= count + CW'(push) - CW'(pop);
         case (state)
            IDLE: begin
               if (count != '0) begin
                  state       <= REQ;
                  mem_req_o   <= 1'b1;
                  mem_addr_o  <= {q_addr[rd_ptr], 2'b00};
                  mem_wdata_o <= q_data[rd_ptr];
                  mem_wstrb_o <= q_strb[rd_ptr];
               end
            end
            default: begin
               if (mem_ack_i) begin
                  if (count > CW'(1)) begin
                     mem_addr_o  <= {q_addr[rd_nxt], 2'b00};
                     mem_wdata_o <= q_data[rd_nxt];
                     mem_wstrb_o <= q_strb[rd_nxt];
                  end else if (push) begin
                     // next head is the entry being written this edge
                     mem_addr_o  <= {st_addr_i[31:2], 2'b00};
                     mem_wdata_o <= a_data;
                     mem_wstrb_o <= a_strb;
                  end else begin
                     state       <= IDLE;
                     mem_req_o   <= 1'b0;
                     mem_addr_o  <= 32'h0;
                     mem_wdata_o <= 32'h0;
                     mem_wstrb_o <= 4'h0;
                  end
               end
            end
         endcase
      end
   end

   // an entry is live when its distance from the head is below count
   always_comb begin
      logic [AW-1:0] off;
      ld_hit_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         off = AW'(i) - rd_ptr;
         if (({1'b0, off} < count) &&
             ({q_addr[i], ld_addr_i[1:0]} == ld_addr_i))
            ld_hit_o = 1'b1;
      end
   end

endmodule
